// File: rtl/im_sched_pkg.sv
// Shared types for the Clos input-module scheduler: CM state encoding and index widths.
package im_sched_pkg;

    typedef enum logic {
        CmFree = 1'b0,
        CmHeld = 1'b1
    } cm_state_e;

    // Index width with a floor of one bit so single-entry vectors still get a pointer.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/im_sched_if.sv
// Request/grant bundle between input ports and the IM scheduler.
// The cms reachability matrix exists only when CMS_MASK_EN is defined.
interface im_sched_if #(
    parameter int unsigned NN = 2,
    parameter int unsigned MN = 2,
    parameter int unsigned SN = 2
);
    logic [NN-1:0]         req;
    logic [NN-1:0][SN-1:0] deci;
    logic [NN-1:0]         eof;
`ifdef CMS_MASK_EN
    logic [MN-1:0][SN-1:0] cms;
`endif
    logic [MN-1:0][NN-1:0] cfg;
    logic [NN-1:0]         gnt;
    logic [MN-1:0]         busy;

`ifdef CMS_MASK_EN
    modport master (output req, deci, eof, cms, input cfg, gnt, busy);
    modport slave  (input req, deci, eof, cms, output cfg, gnt, busy);
`else
    modport master (output req, deci, eof, input cfg, gnt, busy);
    modport slave  (input req, deci, eof, output cfg, gnt, busy);
`endif

endinterface

// File: rtl/im_sched_rr_arb.sv
// Combinational N-way round-robin pick: first request at or after ptr, wrapping.
module im_sched_rr_arb
    import im_sched_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned PW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    int unsigned j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/im_sched.sv
// Clos input-module scheduler: one round-robin CM allocation per cycle, paths held until EoF.
// Optional CMS_MASK_EN restricts each CM to inputs whose decoded direction it can reach.
module im_sched
    import im_sched_pkg::*;
#(
    parameter int unsigned NN = 2,
    parameter int unsigned MN = 2,
    parameter int unsigned SN = 2
) (
    input logic      clk,
    input logic      rst_n,
    im_sched_if.slave bus
);

    localparam int unsigned PW = idx_width(NN);
    localparam int unsigned CW = idx_width(MN);

    cm_state_e             cm_state_q [MN];
    logic [MN-1:0][NN-1:0] cfg_q;
    logic [NN-1:0]         gnt_q;
    logic [PW-1:0]         ptr_q;

    logic [MN-1:0]         busy;
    logic [NN-1:0][MN-1:0] cm_ok;
    logic [NN-1:0]         elig;
    logic [NN-1:0]         rel;
    logic [NN-1:0]         pick_oh;
    logic [PW-1:0]         pick_idx;
    logic                  pick_any;
    logic [CW-1:0]         cm_idx;
    logic                  cm_found;

`ifndef CMS_MASK_EN
    logic unused_deci;
    assign unused_deci = ^bus.deci;
`endif

    // Eligibility uses registered state only, so a CM freed this cycle waits one cycle.
    always_comb begin
        busy  = '0;
        cm_ok = '0;
        elig  = '0;
        for (int unsigned m = 0; m < MN; m++) busy[m] = (cm_state_q[m] == CmHeld);
        for (int unsigned n = 0; n < NN; n++) begin
            for (int unsigned m = 0; m < MN; m++) begin
`ifdef CMS_MASK_EN
                cm_ok[n][m] = ~busy[m] & (|(bus.cms[m] & bus.deci[n]));
`else
                cm_ok[n][m] = ~busy[m];
`endif
            end
            elig[n] = bus.req[n] & ~gnt_q[n] & (|cm_ok[n]);
        end
        rel = bus.eof & gnt_q;
    end

    im_sched_rr_arb #(
        .N (NN)
    ) u_arb (
        .req     (elig),
        .ptr     (ptr_q),
        .gnt     (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        cm_idx   = '0;
        cm_found = 1'b0;
        for (int unsigned m = 0; m < MN; m++) begin
            if (!cm_found && cm_ok[pick_idx][m]) begin
                cm_idx   = CW'(m);
                cm_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned m = 0; m < MN; m++) cm_state_q[m] <= CmFree;
            cfg_q <= '0;
            gnt_q <= '0;
            ptr_q <= '0;
        end else begin
            for (int unsigned m = 0; m < MN; m++) begin
                if (cm_state_q[m] == CmHeld && (|(cfg_q[m] & rel))) begin
                    cm_state_q[m] <= CmFree;
                    cfg_q[m]      <= '0;
                end
            end
            // Granted input had gnt=0 and released inputs had gnt=1, so the masks never overlap.
            gnt_q <= (gnt_q & ~rel) | (pick_any ? pick_oh : '0);
            if (pick_any) begin
                cm_state_q[cm_idx] <= CmHeld;
                cfg_q[cm_idx]      <= pick_oh;
                ptr_q              <= (pick_idx == PW'(NN - 1)) ? '0 : pick_idx + PW'(1);
            end
        end
    end

    assign bus.cfg  = cfg_q;
    assign bus.gnt  = gnt_q;
    assign bus.busy = busy;

endmodule

// File: tb/tb_im_sched.sv
// Scoreboard bench for im_sched with NN=3, MN=2, SN=2; CMS_MASK_EN adds the reachability case.
module tb_im_sched;

    localparam int unsigned NN = 3;
    localparam int unsigned MN = 2;
    localparam int unsigned SN = 2;

    typedef struct {
        string      name;
        logic [5:0] cfg;
        logic [2:0] gnt;
        logic [1:0] busy;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q[$];
    int   tests_run;
    int   tests_failed;

    im_sched_if #(.NN(NN), .MN(MN), .SN(SN)) bus ();

    im_sched #(.NN(NN), .MN(MN), .SN(SN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string field, input logic [5:0] got,
                       input logic [5:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s %s got %b want %b", name, field, got, want);
        end
    endtask

    task automatic push(input string name, input logic [5:0] cfg, input logic [2:0] gnt,
                        input logic [1:0] busy);
        exp_t e;
        e.name = name;
        e.cfg  = cfg;
        e.gnt  = gnt;
        e.busy = busy;
        q.push_back(e);
    endtask

    // Drive inputs for one cycle; expectation describes state after the coming edge.
    task automatic step(input string name, input logic [2:0] req, input logic [2:0] eof,
                        input logic [5:0] cfg, input logic [2:0] gnt, input logic [1:0] busy);
        @(negedge clk);
        bus.req = req;
        bus.eof = eof;
        push(name, cfg, gnt, busy);
        @(posedge clk);
    endtask

    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        push(name, 6'b0, 3'b0, 2'b0);
        rst_n = 1'b0;
        @(posedge clk);
    endtask

    // Monitor: pops expectations after each clock edge or asynchronous reset.
    initial begin : monitor
        exp_t       e;
        logic [5:0] cfg_v;
        forever begin
            @(posedge clk or negedge rst_n);
            #2;
            while (q.size() > 0) begin
                e     = q.pop_front();
                cfg_v = bus.cfg;
                chk(e.name, "cfg", cfg_v, e.cfg);
                chk(e.name, "gnt", {3'b0, bus.gnt}, {3'b0, e.gnt});
                chk(e.name, "busy", {4'b0, bus.busy}, {4'b0, e.busy});
            end
        end
    end

    initial begin : invariants
        forever begin
            @(posedge clk);
            #3;
            for (int m = 0; m < MN; m++) begin
                chk("inv_onehot", "row_ok", {5'b0, $onehot0(bus.cfg[m])}, 6'd1);
                chk("inv_busy_cfg", "busy", {5'b0, bus.busy[m]}, {5'b0, |bus.cfg[m]});
            end
            chk("inv_count", "pop_busy", 6'($countones(bus.busy)), 6'($countones(bus.gnt)));
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin : stim
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.eof      = '0;
        bus.deci     = 6'b01_01_01;
`ifdef CMS_MASK_EN
        bus.cms      = 4'b11_11;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push("reset", 6'b0, 3'b0, 2'b0);
        @(posedge clk);

        step("single_req",   3'b001, 3'b000, 6'b000_001, 3'b001, 2'b01);
        step("hold",         3'b001, 3'b000, 6'b000_001, 3'b001, 2'b01);
        step("release0",     3'b000, 3'b001, 6'b000_000, 3'b000, 2'b00);
        step("two_req_e1",   3'b011, 3'b000, 6'b000_010, 3'b010, 2'b01);
        step("two_req_e2",   3'b011, 3'b000, 6'b001_010, 3'b011, 2'b11);
        step("all_busy",     3'b111, 3'b000, 6'b001_010, 3'b011, 2'b11);
        step("free_no_reuse", 3'b100, 3'b001, 6'b000_010, 3'b010, 2'b01);
        step("reuse_next",   3'b100, 3'b000, 6'b100_010, 3'b110, 2'b11);
        step("release2",     3'b000, 3'b100, 6'b000_010, 3'b010, 2'b01);
        step("rel_and_gnt",  3'b001, 3'b010, 6'b001_000, 3'b001, 2'b10);
        step("freed_cm0",    3'b010, 3'b000, 6'b001_010, 3'b011, 2'b11);

        async_reset("async_rst");
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 3'b000;
        bus.eof = 3'b011;
        push("spurious_eof", 6'b0, 3'b0, 2'b0);
        @(posedge clk);
        step("post_rst_gnt", 3'b100, 3'b000, 6'b000_100, 3'b100, 2'b01);

`ifdef CMS_MASK_EN
        async_reset("mask_rst");
        @(negedge clk);
        rst_n       = 1'b1;
        bus.cms[0]  = 2'b01;
        bus.cms[1]  = 2'b10;
        bus.deci[0] = 2'b10;
        bus.deci[1] = 2'b10;
        bus.deci[2] = 2'b01;
        bus.req     = 3'b000;
        bus.eof     = 3'b000;
        push("mask_idle", 6'b0, 3'b0, 2'b0);
        @(posedge clk);
        step("mask_cm1",     3'b001, 3'b000, 6'b001_000, 3'b001, 2'b10);
        step("mask_skip",    3'b111, 3'b000, 6'b001_100, 3'b101, 2'b11);
`endif

        @(negedge clk);
        bus.req = '0;
        bus.eof = '0;
        repeat (3) @(posedge clk);
        #4;
        chk("drain", "pending", 6'(q.size()), 6'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
